// File: rtl/ct_spsram_req_ctrl.sv
// Requester-side controller for a single-port SRAM: zero-fills the array after reset, then
// turns a valid/ready request stream into registered SRAM pin activity with in-order responses.
module ct_spsram_req_ctrl #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 144
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic [ADDR_WIDTH-1:0]   a_q, a_d;
    logic                    cen_q, cen_d;
    logic                    gwen_q, gwen_d;
    logic [DATA_WIDTH-1:0]   wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   d_q, d_d;
    logic                    s1_q, s2_q;

    logic [DATA_WIDTH-1:0]   fifo_q [3];
    logic [1:0]              rd_ptr_q, wr_ptr_q, count_q;

    logic                    accept, push, pop;
    logic [2:0]              occ;

    assign init_done = (state_q == StRun);
    assign rsp_vld   = (count_q != 2'd0);
    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign pop       = rsp_vld & rsp_rdy;
    assign push      = s2_q;

    // Buffered plus in-flight reads, crediting a same-cycle pop, must leave room for one more.
    assign occ     = 3'(count_q) + 3'(s1_q) + 3'(s2_q) - 3'(pop);
    assign req_rdy = (state_q == StRun) && (occ < 3'd3);
    assign accept  = req_vld & req_rdy;

    assign sram_a    = a_q;
    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_d    = d_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cen_d      = 1'b1;
        gwen_d     = 1'b1;
        wen_d      = '1;
        a_d        = a_q;
        d_d        = d_q;
        case (state_q)
            StInit: begin
                cen_d      = 1'b0;
                gwen_d     = 1'b0;
                wen_d      = '0;
                d_d        = '0;
                a_d        = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LastAddr) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    cen_d = 1'b0;
                    a_d   = req_addr;
                    if (req_wr) begin
                        gwen_d = 1'b0;
                        wen_d  = ~req_wmask;
                        d_d    = req_wdata;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            a_q        <= '0;
            cen_q      <= 1'b1;
            gwen_q     <= 1'b1;
            wen_q      <= '1;
            d_q        <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            a_q        <= a_d;
            cen_q      <= cen_d;
            gwen_q     <= gwen_d;
            wen_q      <= wen_d;
            d_q        <= d_d;
            s1_q       <= accept & ~req_wr;
            s2_q       <= s1_q;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_q;
                wr_ptr_q         <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
